// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester-side and FIFO-write-port signals shared by the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned GNT_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          wfull;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;
  logic                          busy;
  logic [GNT_W-1:0]              gnt_id;

  // Environment side: requesters plus the FIFO full flag.
  modport master (
    output req, req_data, wfull,
    input  ack, winc, wdata, busy, gnt_id
  );

  // Arbiter side.
  modport slave (
    input  req, req_data, wfull,
    output ack, winc, wdata, busy, gnt_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Burst-limited round-robin arbiter for the FIFO write port (write-clock domain).
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4,
  localparam int unsigned GNT_W     = $clog2(NUM_REQ)
) (
  input logic              wclk,
  input logic              wrst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [GNT_W-1:0] gnt_id_q, gnt_id_d;
  logic [GNT_W-1:0] last_id_q, last_id_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [GNT_W-1:0]      scan_base;
  logic [GNT_W-1:0]      cand;
  logic [GNT_W-1:0]      pick_id;
  logic                  pick_found;
  logic                  accept;
  logic                  release_gnt;
  logic [NUM_REQ-1:0]    ack;
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;

  // Round-robin pick: scan base+1 .. base+NUM_REQ, so base itself is tried last.
  always_comb begin
    scan_base  = (state_q == StIdle) ? last_id_q : gnt_id_q;
    cand       = '0;
    pick_id    = '0;
    pick_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = GNT_W'((32'(scan_base) + k) % NUM_REQ);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Next-state and write-port outputs.
  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    last_id_d   = last_id_q;
    burst_cnt_d = burst_cnt_q;
    ack         = '0;
    winc        = 1'b0;
    wdata       = '0;
    accept      = 1'b0;
    release_gnt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d     = StGrant;
          gnt_id_d    = pick_id;
          burst_cnt_d = '0;
        end
      end
      StGrant: begin
        wdata  = bus.req_data[32'(gnt_id_q) * DATA_WIDTH +: DATA_WIDTH];
        // A full FIFO stalls the burst; the grant is kept.
        accept = bus.req[gnt_id_q] & ~bus.wfull;
        if (accept) begin
          winc          = 1'b1;
          ack[gnt_id_q] = 1'b1;
          burst_cnt_d   = burst_cnt_q + CNT_W'(1);
        end
        release_gnt = !bus.req[gnt_id_q] ||
                      (accept && (burst_cnt_q + CNT_W'(1) == CNT_W'(BURST_LEN)));
        if (release_gnt) begin
          last_id_d   = gnt_id_q;
          burst_cnt_d = '0;
          // Direct hand-over keeps the write stream free of bubbles.
          if (pick_found) begin
            gnt_id_d = pick_id;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; requester 0 wins first after reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q     <= StIdle;
      gnt_id_q    <= '0;
      last_id_q   <= GNT_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign bus.ack    = ack;
  assign bus.winc   = winc;
  assign bus.wdata  = wdata;
  assign bus.busy   = (state_q == StGrant);
  assign bus.gnt_id = gnt_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios then random traffic.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int GW = $clog2(NR);

  typedef struct packed {
    logic          busy;
    logic [GW-1:0] gnt;
    logic [DW-1:0] wdata;
    logic          winc;
  } status_t;

  typedef struct packed {
    logic [GW-1:0] id;
    logic [DW-1:0] data;
  } write_t;

  logic wclk;
  logic wrst;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .wclk(wclk),
    .wrst(wrst),
    .bus (bus)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  status_t sq[$];
  write_t  wq[$];
  int      total;
  int      bad;
  bit      en;
  int      ack0_cnt;

  // Reference model: owner = -1 means nobody holds the port.
  int            m_owner;
  int            m_cnt;
  int            m_last;
  int            m_gnt;
  logic [DW-1:0] d[NR];
  logic [NR-1:0] cur_req;
  int            last_wr_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] r, input int from);
    for (int k = 1; k <= NR; k++) begin
      if (r[(from + k) % NR]) return (from + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_last  = NR - 1;
    m_gnt   = 0;
  endtask

  // Drive one cycle, predict its outputs, advance the model, then cross the edge.
  task automatic step(input logic [NR-1:0] r, input logic f, input logic rst);
    status_t s;
    write_t  w;
    int      nxt;
    bus.req   = r;
    bus.wfull = f;
    wrst      = rst;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = d[i];
    last_wr_id = -1;
    s.busy  = (m_owner >= 0);
    s.gnt   = GW'(m_gnt);
    s.wdata = (m_owner >= 0) ? d[m_owner] : '0;
    s.winc  = 1'b0;
    if (m_owner >= 0 && r[m_owner] && !f) begin
      s.winc     = 1'b1;
      w.id       = GW'(m_owner);
      w.data     = d[m_owner];
      wq.push_back(w);
      last_wr_id = m_owner;
      m_cnt++;
    end
    sq.push_back(s);
    if (rst) begin
      model_reset();
    end else if (m_owner >= 0) begin
      if (!r[m_owner] || m_cnt == BL) begin
        m_last  = m_owner;
        m_owner = rr_pick(r, m_owner);
        if (m_owner >= 0) begin
          m_gnt = m_owner;
          m_cnt = 0;
        end
      end
    end else begin
      nxt = rr_pick(r, m_last);
      if (nxt >= 0) begin
        m_owner = nxt;
        m_gnt   = nxt;
        m_cnt   = 0;
      end
    end
    @(posedge wclk);
    #1;
    if (last_wr_id >= 0) d[last_wr_id] = DW'($urandom);
  endtask

  // Monitor: every cycle check status; on each write pop and compare the write record.
  always @(negedge wclk) begin
    status_t s;
    write_t  w;
    if (en) begin
      if (bus.ack[0]) ack0_cnt++;
      if (sq.size() == 0) begin
        check("status_queue_nonempty", 32'd0, 32'd1);
      end else begin
        s = sq.pop_front();
        check("busy", 32'(bus.busy), 32'(s.busy));
        check("gnt_id", 32'(bus.gnt_id), 32'(s.gnt));
        check("wdata_bus", 32'(bus.wdata), 32'(s.wdata));
        check("winc", 32'(bus.winc), 32'(s.winc));
        check("winc_eq_or_ack", 32'(bus.winc), 32'(|bus.ack));
      end
      if (bus.winc) begin
        if (wq.size() == 0) begin
          check("write_expected", 32'd0, 32'd1);
        end else begin
          w = wq.pop_front();
          check("ack_onehot", 32'(bus.ack), 32'(1) << w.id);
          check("write_data", 32'(bus.wdata), 32'(w.data));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] r;
    total = 0;
    bad   = 0;
    en    = 1'b0;
    ack0_cnt = 0;
    cur_req  = '0;
    for (int i = 0; i < NR; i++) d[i] = DW'($urandom);
    bus.req      = '0;
    bus.req_data = '0;
    bus.wfull    = 1'b0;
    wrst         = 1'b1;
    @(posedge wclk);
    #1;
    model_reset();
    en = 1'b1;

    // Single uncontested requester: 6 acks over 7 cycles, no gap at re-grant.
    step('0, 1'b0, 1'b1);
    ack0_cnt = 0;
    repeat (7) step(4'b0001, 1'b0, 1'b0);
    check("req0_ack_count", 32'(ack0_cnt), 32'd6);

    // All requesting: 0,1,2,3,0 rotation.
    step('0, 1'b0, 1'b1);
    repeat (20) step(4'b1111, 1'b0, 1'b0);

    // Requester 2 stalled by wfull for 3 cycles mid-burst.
    step('0, 1'b0, 1'b1);
    repeat (2) step(4'b0100, 1'b0, 1'b0);
    repeat (3) step(4'b0100, 1'b1, 1'b0);
    repeat (6) step(4'b0100, 1'b0, 1'b0);

    // Wrap-around after reset (last_id = 3) then hand-over to 2.
    step('0, 1'b0, 1'b1);
    repeat (12) step(4'b0101, 1'b0, 1'b0);

    // Requester 1 drops after one ack with 3 pending.
    step('0, 1'b0, 1'b1);
    repeat (2) step(4'b0010, 1'b0, 1'b0);
    repeat (4) step(4'b1000, 1'b0, 1'b0);
    step(4'b1010, 1'b0, 1'b0);

    // Reset mid-burst with requester 3 held through it.
    step('0, 1'b0, 1'b1);
    repeat (2) step(4'b1000, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b1);
    repeat (4) step(4'b1000, 1'b0, 1'b0);

    // Random traffic obeying the hold-until-ack contract (drops are legal).
    cur_req = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (cur_req[i]) begin
          if (last_wr_id == i) cur_req[i] = ($urandom_range(1, 0) == 1);
          else if ($urandom_range(19, 0) == 0) cur_req[i] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          cur_req[i] = 1'b1;
          d[i]       = DW'($urandom);
        end
      end
      r = cur_req;
      step(r, ($urandom_range(3, 0) == 0), ($urandom_range(199, 0) == 0));
    end

    en = 1'b0;
    check("status_queue_drained", 32'(sq.size()), 32'd0);
    check("write_queue_drained", 32'(wq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
